ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Fetch sequencer for the RV32I instruction memory, which has a registered word address and 1-cycle latency. The block owns the PC and drives the memory's enable and byte address. It tracks the single in-flight read and buffers returned words in a small FIFO toward decode with a valid/ready handshake. Branch/jump redirects flush all wrong-path state, and misaligned redirect targets are trapped.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
IMEM_DEPTH_WORDS, 1024, words in the instruction memory; used for the out-of-bounds flag
FIFO_DEPTH, 3, output buffer entries (min 2); 3 sustains 1 instr/cycle

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_en  out  1  memory address-capture enable
imem_addr  out  32  byte address to memory
imem_rdata  in  32  memory data for the address captured on the previous enabled edge
redirect_valid  in  1  redirect request, single cycle
redirect_pc  in  32  redirect target byte address
out_valid  out  1  fetched instruction available
out_ready  in  1  decode accepts
out_instr  out  32  instruction word
out_pc  out  32  byte PC of out_instr
out_oob  out  1  out_pc word index >= IMEM_DEPTH_WORDS; instr is the NOP returned by memory
fetch_fault  out  1  misaligned redirect trapped
perf_issue_cnt  out  32  see Optional Feature
perf_stall_cnt  out  32  see Optional Feature
perf_flush_cnt  out  32  see Optional Feature

Behaviour:
- Reset (async assert, release sync to clk) sets:
  - state=IDLE, pc_q=RESET_PC.
  - FIFO empty, inflight_q=0.
  - out_valid=0, fetch_fault=0, imem_en=0, imem_addr=RESET_PC.
  - Counters=0.
- States:
  - IDLE: one cycle, imem_en=0, then RUN.
  - RUN: normal fetch.
  - FAULT: imem_en=0, fetch_fault=1, out_valid=0.
- Credit rule, RUN with no redirect: issue = (fifo_count + inflight_q < FIFO_DEPTH).
  - Uses registered terms only; no combinational path from out_ready to imem_en.
  - On issue: imem_en=1, imem_addr=pc_q, pc_q<=pc_q+4 (wraps mod 2^32), inflight_q<=1, inflight_pc_q<=pc_q.
  - When not issuing: imem_en=0, so the memory holds its address.
- Return path: when inflight_q=1, imem_rdata is valid this cycle and is written into the FIFO with inflight_pc_q at the edge.
  - If no new issue that cycle, inflight_q<=0.
  - The credit rule guarantees the FIFO has space.
- Latency: issue in cycle N, data in cycle N+1, out_valid in cycle N+2.
- Output: out_valid = FIFO not empty and !redirect_valid and state!=FAULT.
  - Pop on out_valid && out_ready.
  - out_instr/out_pc/out_oob come from the FIFO head and hold stable while out_valid && !out_ready.
  - FIFO pointers wrap at FIFO_DEPTH (not power of 2).
  - Push and pop in the same cycle leave the count unchanged.
- Redirect has the highest priority and is honoured in any state except IDLE. In IDLE it is latched and applied on entry to RUN.
  - FIFO flushed (count<=0).
  - The in-flight return is discarded, not written.
  - Any pop that cycle is suppressed.
  - Aligned target (redirect_pc[1:0]==0): issue redirect_pc this same cycle (imem_en=1, imem_addr=redirect_pc), pc_q<=redirect_pc+4, inflight_q<=1, state<=RUN, fetch_fault<=0.
  - Misaligned target: no issue, inflight_q<=0, state<=FAULT.
- FAULT exits only via an aligned redirect or reset.
- out_oob is computed at FIFO push from inflight_pc_q[31:2] >= IMEM_DEPTH_WORDS. No trap; the instruction passes through.
- Reset mid-operation: all state cleared immediately. The memory's held address is ignored because inflight_q=0.

Optional Feature:
IFETCH_PERF_EN defined: three 32-bit saturating counters.
- perf_issue_cnt: +1 per imem_en=1 cycle.
- perf_stall_cnt: +1 per RUN cycle with out_valid && !out_ready.
- perf_flush_cnt: +1 per redirect that discards at least one FIFO entry or an in-flight return.
- All three cleared by rst.

IFETCH_PERF_EN undefined: the counter ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset release, memory holds sequential words, out_ready=1 -> out_pc 0x0,0x4,0x8,... one per cycle; first out_valid 3 cycles after rst deassertion.
- out_ready=0 for 10 cycles after the first valid -> exactly FIFO_DEPTH entries buffered, imem_en=0 and out_instr/out_pc stable; resume -> no word lost or duplicated.
- Redirect to 0x100 while FIFO is full with an in-flight read -> out_valid=0 that cycle, imem_addr=0x100 with imem_en=1 the same cycle; next outputs 0x100,0x104; no old PC appears.
- Redirect to 0x102 -> fetch_fault=1, imem_en=0, out_valid=0 indefinitely; then redirect to 0x200 -> fault clears, 0x200 delivered.
- Redirect to 0xFFC (word 1023), then continue -> 0xFFC with out_oob=0, 0x1000 with out_oob=1 and out_instr=0x00000013.
- With IFETCH_PERF_EN: 20 sequential fetches, 5 stall cycles and 1 flushing redirect -> counters read 20+, 5, 1; without the macro all read 0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: RV32I fetch sequencer in front of a 1-cycle-latency instruction
// memory with a registered word address. Owns the PC, keeps one read in
// flight, buffers returned words toward decode and handles redirects.
//
// Build option: define IFETCH_PERF_EN to add saturating issue/stall/flush
// counters; without it the perf ports are tied to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset, no fetch; a redirect seen here is held
// RUN   | normal fetch under the FIFO credit rule
// FAULT | misaligned redirect trapped; waits for an aligned redirect

module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter int          IMEM_DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH       = 3
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_oob,
   output logic        fetch_fault,
   output logic [31:0] perf_issue_cnt,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR    = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_CMP   = (CW+1)'(FIFO_DEPTH);
   localparam logic [29:0]   DEPTH_WORDS = 30'(IMEM_DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t        state_q;
   logic [31:0]   pc_q;
   logic          inflight_q;
   logic [31:0]   inflight_pc_q;
   logic          pend_q;
   logic [31:0]   pend_pc_q;
   logic          fault_q;

   logic [31:0]   fifo_instr_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
   logic          fifo_oob_q   [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   logic          redir_act;
   logic [31:0]   redir_tgt;
   logic          redir_ok;
   logic          credit_ok;
   logic          issue;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A redirect held from IDLE is applied in the first RUN cycle.
   assign redir_act = (state_q != IDLE) && (redirect_valid || pend_q);
   assign redir_tgt = redirect_valid ? redirect_pc : pend_pc_q;
   assign redir_ok  = redir_act && (redir_tgt[1:0] == 2'b00);

   // Credit uses registered terms only, keeping out_ready off the imem_en path.
   assign credit_ok = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_CMP;
   assign issue     = redir_ok || ((state_q == RUN) && !redir_act && credit_ok);

   assign imem_en   = issue;
   assign imem_addr = redir_act ? redir_tgt : pc_q;

   assign push      = inflight_q && !redir_act;
   assign out_valid = (count_q != '0) && !redirect_valid && (state_q != FAULT);
   assign pop       = out_valid && out_ready && !redir_act;

   assign out_instr   = fifo_instr_q[rd_ptr_q];
   assign out_pc      = fifo_pc_q[rd_ptr_q];
   assign out_oob     = fifo_oob_q[rd_ptr_q];
   assign fetch_fault = fault_q;

   // Sequencer: state, PC, in-flight tracking and fault flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
         pend_q        <= 1'b0;
         pend_pc_q     <= '0;
         fault_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= RUN;
               if (redirect_valid) begin
                  pend_q    <= 1'b1;
                  pend_pc_q <= redirect_pc;
               end
            end
            default: begin
               pend_q <= 1'b0;
               if (redir_act) begin
                  if (redir_ok) begin
                     pc_q          <= redir_tgt + 32'd4;
                     inflight_q    <= 1'b1;
                     inflight_pc_q <= redir_tgt;
                     state_q       <= RUN;
                     fault_q       <= 1'b0;
                  end else begin
                     inflight_q <= 1'b0;
                     state_q    <= FAULT;
                     fault_q    <= 1'b1;
                  end
               end else if (issue) begin
                  pc_q          <= pc_q + 32'd4;
                  inflight_q    <= 1'b1;
                  inflight_pc_q <= pc_q;
               end else begin
                  inflight_q <= 1'b0;
               end
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (redir_act) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; out-of-bounds flag is resolved once at write time.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= imem_rdata;
         fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
         fifo_oob_q[wr_ptr_q]   <= (inflight_pc_q[31:2] >= DEPTH_WORDS);
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] issue_cnt_q;
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (issue && (issue_cnt_q != '1))
            issue_cnt_q <= issue_cnt_q + 32'd1;
         if ((state_q == RUN) && out_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redir_act && ((count_q != '0) || inflight_q) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign perf_issue_cnt = issue_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   assign perf_issue_cnt = '0;
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a behavioural 1-cycle instruction memory.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_oob;
   logic        fetch_fault;
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   int checks   = 0;
   int failures = 0;

`ifdef IFETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 clk = ~clk;

   ifetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_oob        (out_oob),
      .fetch_fault    (fetch_fault),
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
   );

   // Memory: registered address, word = 0xA5000000|addr, NOP beyond 1024 words.
   logic [31:0] mem_addr_q = 32'h0;
   always @(posedge clk) if (imem_en) mem_addr_q <= imem_addr;
   assign imem_rdata = (mem_addr_q[31:2] < 30'd1024) ? (32'hA500_0000 | mem_addr_q)
                                                     : 32'h0000_0013;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_instr"}, out_instr, 32'hA500_0000 | pc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_en", {31'b0, imem_en}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
      chk("rst_perf_issue", perf_issue_cnt, 32'd0);
      chk("rst_perf_stall", perf_stall_cnt, 32'd0);
      chk("rst_perf_flush", perf_flush_cnt, 32'd0);

      // Release and sequential streaming
      tick(); rst = 1'b0; #1;
      chk("idle_en", {31'b0, imem_en}, 32'd0);
      tick(); #1;
      chk("issue0_en", {31'b0, imem_en}, 32'd1);
      chk("issue0_addr", imem_addr, 32'h0);
      chk("issue0_valid", {31'b0, out_valid}, 32'd0);
      tick(); #1;
      chk("issue1_en", {31'b0, imem_en}, 32'd1);
      chk("issue1_addr", imem_addr, 32'h4);
      chk("issue1_valid", {31'b0, out_valid}, 32'd0);
      tick(); #1;
      expect_head("first", 32'h0);
      for (int k = 1; k <= 4; k++) begin
         tick(); #1;
         expect_head("stream", 32'(4 * k));
      end

      // Backpressure: three entries buffered, fetch stops, head holds
      for (int i = 0; i < 10; i++) begin
         tick(); out_ready = 1'b0; #1;
         expect_head("stall", 32'h14);
         if (i >= 1) chk("stall_en", {31'b0, imem_en}, 32'd0);
      end
      for (int k = 0; k < 5; k++) begin
         tick(); out_ready = 1'b1; #1;
         expect_head("resume", 32'h14 + 32'(4 * k));
      end

      // Redirect with buffered entries and a read in flight
      tick(); out_ready = 1'b0; #1;
      expect_head("pre_redir", 32'h28);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1; #1;
      chk("redir_valid", {31'b0, out_valid}, 32'd0);
      chk("redir_en", {31'b0, imem_en}, 32'd1);
      chk("redir_addr", imem_addr, 32'h100);
      tick(); redirect_valid = 1'b0; #1;
      chk("redir1_valid", {31'b0, out_valid}, 32'd0);
      chk("redir1_addr", imem_addr, 32'h104);
      tick(); #1;
      expect_head("redir_a", 32'h100);
      tick(); #1;
      expect_head("redir_b", 32'h104);
      chk("perf_issue", perf_issue_cnt, PERF ? 32'd16 : 32'd0);
      chk("perf_stall", perf_stall_cnt, PERF ? 32'd11 : 32'd0);
      chk("perf_flush", perf_flush_cnt, PERF ? 32'd1 : 32'd0);

      // Misaligned redirect traps until an aligned one arrives
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
      chk("mis_valid", {31'b0, out_valid}, 32'd0);
      chk("mis_en", {31'b0, imem_en}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick(); redirect_valid = 1'b0; #1;
         chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
         chk("fault_en", {31'b0, imem_en}, 32'd0);
         chk("fault_valid", {31'b0, out_valid}, 32'd0);
      end
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
      chk("exit_en", {31'b0, imem_en}, 32'd1);
      chk("exit_addr", imem_addr, 32'h200);
      tick(); redirect_valid = 1'b0; #1;
      chk("exit_fault", {31'b0, fetch_fault}, 32'd0);
      chk("exit_addr2", imem_addr, 32'h204);
      tick(); #1;
      expect_head("post_fault_a", 32'h200);
      tick(); #1;
      expect_head("post_fault_b", 32'h204);

      // Last in-range word and the first out-of-range one
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFC; #1;
      chk("oob_redir_addr", imem_addr, 32'hFFC);
      tick(); redirect_valid = 1'b0; #1;
      chk("oob_next_addr", imem_addr, 32'h1000);
      tick(); #1;
      expect_head("oob_last", 32'hFFC);
      chk("oob_last_flag", {31'b0, out_oob}, 32'd0);
      tick(); #1;
      chk("oob_valid", {31'b0, out_valid}, 32'd1);
      chk("oob_pc", out_pc, 32'h1000);
      chk("oob_instr", out_instr, 32'h0000_0013);
      chk("oob_flag", {31'b0, out_oob}, 32'd1);
      chk("perf_flush2", perf_flush_cnt, PERF ? 32'd3 : 32'd0);
      chk("perf_stall2", perf_stall_cnt, PERF ? 32'd11 : 32'd0);
      tick(); #1;
      chk("oob2_pc", out_pc, 32'h1004);
      chk("oob2_flag", {31'b0, out_oob}, 32'd1);

      // Reset mid-stream, then a redirect arriving during IDLE
      tick(); rst = 1'b1; #1;
      chk("mrst_valid", {31'b0, out_valid}, 32'd0);
      chk("mrst_en", {31'b0, imem_en}, 32'd0);
      chk("mrst_addr", imem_addr, 32'h0);
      chk("mrst_perf_issue", perf_issue_cnt, 32'd0);
      tick(); rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      chk("idle_redir_en", {31'b0, imem_en}, 32'd0);
      tick(); redirect_valid = 1'b0; #1;
      chk("idle_redir_issue", {31'b0, imem_en}, 32'd1);
      chk("idle_redir_addr", imem_addr, 32'h40);
      tick(); #1;
      chk("idle_redir_next", imem_addr, 32'h44);
      chk("idle_redir_nv", {31'b0, out_valid}, 32'd0);
      tick(); #1;
      expect_head("idle_redir_head", 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
